writeback_buf: RTL

- Parametrised successor to the single-register writeback stage.
- Accepts retiring results from memory-access stage via valid/ready handshake and buffers up to DEPTH pending register-file writes in a FIFO.
- Drains them to the register-file write port under a separate valid/ready handshake; lets the RF port be shared or blocked without stalling upstream until the buffer fills.
- Optional youngest-match bypass lookup serves hazard/forwarding logic in decode.

---
 rtl/writeback_buf_pkg.sv | 7 +
 rtl/wb_buf_mem.sv | 27 ++
 rtl/writeback_buf.sv | 100 ++++++++++
 3 files changed

// File: rtl/writeback_buf_pkg.sv
// Shared CPU constants for the writeback buffer: register widths, default depth and the r0 id.
package writeback_buf_pkg;
  localparam int CPU_REGNO_WIDTH = 5;
  localparam int CPU_REG_WIDTH   = 32;
  localparam int WB_BUF_DEPTH    = 4;
  localparam logic [CPU_REGNO_WIDTH-1:0] CPU_REG_ZERO = '0;
endpackage

// File: rtl/wb_buf_mem.sv
// Entry storage for the writeback buffer: one write port, one async read port,
// plus the whole array flattened for the bypass search.
module wb_buf_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [AW-1:0]          raddr,
  output logic [WIDTH-1:0]       rdata,
  output logic [DEPTH*WIDTH-1:0] flat
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign flat[i*WIDTH +: WIDTH] = mem[i];
  end
endmodule

// File: rtl/writeback_buf.sv
// DEPTH-entry in-order buffer between the memory stage and the register-file write port.
// Define WRITEBACK_BUF_BYPASS_EN to add the youngest-match bypass lookup for decode.
module writeback_buf
  import writeback_buf_pkg::*;
#(
  parameter int REGNO_WIDTH = CPU_REGNO_WIDTH,
  parameter int REG_WIDTH   = CPU_REG_WIDTH,
  parameter int DEPTH       = WB_BUF_DEPTH,
  parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_core_stall,
  input  logic                   i_valid,
  input  logic [REGNO_WIDTH-1:0] i_rd_no,
  input  logic [REG_WIDTH-1:0]   i_rd_val,
  output logic                   o_ready,
  output logic                   o_wr_valid,
  output logic [REGNO_WIDTH-1:0] o_rd_no,
  output logic [REG_WIDTH-1:0]   o_rd_val,
  input  logic                   i_wr_ready,
  output logic [CNT_WIDTH-1:0]   o_count,
  input  logic [REGNO_WIDTH-1:0] i_byp_no,
  output logic                   o_byp_hit,
  output logic [REG_WIDTH-1:0]   o_byp_val
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = REGNO_WIDTH + REG_WIDTH;

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]   count;
  logic                   push, pop;
  logic [EW-1:0]          head;
  logic [DEPTH*EW-1:0]    mem_flat;

  assign o_ready    = (count != CNT_WIDTH'(DEPTH));
  // r0 writes complete the handshake but are never stored.
  assign push       = i_valid & o_ready & ~i_core_stall & (i_rd_no != REGNO_WIDTH'(CPU_REG_ZERO));
  assign o_wr_valid = (count != '0) & ~i_core_stall;
  assign pop        = o_wr_valid & i_wr_ready;
  assign o_rd_no    = o_wr_valid ? head[EW-1:REG_WIDTH] : '0;
  assign o_rd_val   = o_wr_valid ? head[REG_WIDTH-1:0]  : '0;
  assign o_count    = count;

  wb_buf_mem #(.DEPTH(DEPTH), .WIDTH(EW), .AW(PTR_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({i_rd_no, i_rd_val}),
    .raddr (rd_ptr),
    .rdata (head),
    .flat  (mem_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WRITEBACK_BUF_BYPASS_EN
  logic [PTR_W-1:0]       age_idx [DEPTH];
  logic [REGNO_WIDTH-1:0] ent_no  [DEPTH];
  logic [REG_WIDTH-1:0]   ent_val [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_byp
    assign age_idx[i] = rd_ptr + PTR_W'(i);
    assign ent_no[i]  = mem_flat[i*EW+REG_WIDTH +: REGNO_WIDTH];
    assign ent_val[i] = mem_flat[i*EW +: REG_WIDTH];
  end

  // Walk oldest to youngest so the last occupied match wins.
  always_comb begin
    o_byp_hit = 1'b0;
    o_byp_val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_WIDTH'(k) < count) && (i_byp_no != REGNO_WIDTH'(CPU_REG_ZERO)) &&
          (ent_no[age_idx[k]] == i_byp_no)) begin
        o_byp_hit = 1'b1;
        o_byp_val = ent_val[age_idx[k]];
      end
    end
  end
`else
  logic byp_unused;
  assign byp_unused = ^{i_byp_no, mem_flat};
  assign o_byp_hit  = 1'b0;
  assign o_byp_val  = '0;
`endif
endmodule
